tone_synth: RTL and testbench
=============================

# tone_synth

Parametrised square-wave note synthesiser for the audio path. It replaces the fixed seven-counter note generator with a single reloadable divider. It generalises note count, output width, octave shift and volume, and adds deterministic key priority and phase restart on note change. The block sits between the key/switch decoder and the speaker DAC driver, and updates its output only on the DAC sample strobe.

## Interface
- `NUM_NOTES`, default 7: number of selectable notes; `sw` width. Must be ≤ depth of `HALF_P` table in package.
- `CNT_W`, default 18: divider counter width; must hold the largest `HALF_P` entry.
- `OUT_W`, default 12: sample width; must be an integer multiple of `VOL_W`.
- `VOL_W`, default 4: volume input width.
- `OCT_W`, default 2: octave-shift input width.
- `CLK`  in  1: system clock, 100 MHz. One clock; reset is synchronous and active-high.
- `RST`  in  1: synchronous, active-high reset.
- `sample_en`  in  1: single-cycle DAC sample strobe in the `CLK` domain.
- `sw`  in  NUM_NOTES: note keys; bit i selects note i.
- `oct`  in  OCT_W: octave up-shift; half-period divided by 2^oct.
- `vol`  in  VOL_W: amplitude; 0 = silent.
- `speaker_out`  out  OUT_W: sample to DAC.
- `note_active`  out  1: a note was sounding at the last sample.
- `note_idx`  out  $clog2(NUM_NOTES): index of the current selected note, registered.

## Operation
- Decode: `sel_valid` = |sw. `sel_idx` = lowest set bit of `sw`, so the lowest index wins on multi-key press.
- Selection registers: `idx_q`, `valid_q` and `oct_q` load from the decode every cycle.
- Limit: `limit` = max(HALF_P[idx_q] >> oct_q, 1), width CNT_W.
- Restart: if the decoded (valid, idx, oct) differs from the registered values at an edge, then `cnt` ← 0 and `phase` ← 0 on that edge. Restart has priority over counting.
- Idle: if `valid_q`=0, `cnt` is held at 0 and `phase` at 0.
- Count: otherwise, if `cnt`==limit then `cnt` ← 0 and `phase` toggles; else `cnt` ← cnt+1. Half-period = limit+1 cycles.
- Level: `level` = `vol` replicated OUT_W/VOL_W times. Examples: vol=4'hF → 12'hFFF; vol=4'h8 → 12'h888.
- On `sample_en`:
  - `speaker_out` ← (valid_q & phase) ? level : 0
  - `note_active` ← valid_q
- Without `sample_en`, both outputs hold.
- `note_idx` follows `idx_q` continuously. It is 0 when no key is pressed.

## Timing
- Reset values: `speaker_out`=0, `note_active`=0, `note_idx`=0, `cnt`=0, `phase`=0, selection registers 0. The reset values appear one edge after `RST` is sampled high.
- Reset mid-note: outputs go to 0 on that edge. `RST` overrides `sample_en`.
- After a restart at edge E, `phase` first rises at edge E+limit+1, then toggles every limit+1 cycles.
- Output latency: a key press applied before edge E is first reflected in `speaker_out` at the first `sample_en` edge after E+limit+1.
- Key release (sw → 0) before edge E: `speaker_out`=0 at the first `sample_en` edge after E.
- `sample_en` coinciding with a restart edge samples the pre-restart `valid_q` and `phase`.
- `vol` is sampled at the `sample_en` edge, so a volume change never restarts phase.
- A change of `oct` restarts phase, the same as a note change.

## Structure
- Package `tone_pkg` holds:
  - `HALF_P` localparam array: 191112, 170261, 151685, 143172, 127552, 113636, 101238 (DOH..TI at 100 MHz, 0-based half-period count), plus room for extension.
  - Note index constants `N_DOH`..`N_TI`.
- Sub-module `tone_divider`: reloadable `cnt`/`phase` counter with `restart`, `enable` and `limit` inputs.
- The top level holds the decode, the selection registers, the level generation and the output registers.

## Test plan
- Reset, then `sw`=7'b0000001, oct=0, vol=4'hF, `sample_en` every 2268 cycles → `phase` toggles every 191113 cycles; `speaker_out` takes only the values 12'hFFF and 0.
- `sw`=7'b0000001, oct=2 → limit 47778; `phase` toggles every 47779 cycles.
- Multi-key press `sw`=7'b0000110 → `note_idx`=1, half-period 170262 cycles. Then change `sw` to 7'b0000100 → restart: `cnt`=0, `phase`=0 next edge, `note_idx`=2.
- vol=4'h8 while `phase`=1 at a `sample_en` edge → `speaker_out`=12'h888. vol=0 → `speaker_out`=0 with `note_active`=1.
- Release `sw`→0 → at the next `sample_en`, `speaker_out`=0 and `note_active`=0; `cnt` held at 0.
- Assert `RST` mid-note, coincident with `sample_en` → all outputs 0 on that edge. After release, the waveform restarts with the first rise at limit+1 cycles.

Source files
------------

// File: rtl/tone_synth_pkg.sv
// tone_pkg: shared constants for the square-wave note synthesiser.
//   HALF_P     - 0-based half-period counts at 100 MHz, indexed by note.
//                Spare entries are 0 and clamp to the minimum limit of 1.
//   N_DOH..N_TI - note index constants.
//   note_limit - half-period after octave shift, clamped to at least 1.
package tone_pkg;

  localparam int HP_IDX_W     = 3;
  localparam int HALF_P_DEPTH = 1 << HP_IDX_W;

  localparam logic [31:0] HALF_P [HALF_P_DEPTH] = '{
    32'd191112, 32'd170261, 32'd151685, 32'd143172,
    32'd127552, 32'd113636, 32'd101238, 32'd0
  };

  localparam int N_DOH = 0;
  localparam int N_RE  = 1;
  localparam int N_MI  = 2;
  localparam int N_FA  = 3;
  localparam int N_SOL = 4;
  localparam int N_LA  = 5;
  localparam int N_TI  = 6;

  // A limit of 0 would make the divider toggle every cycle with no
  // count phase, so very high octave shifts bottom out at 1.
  function automatic logic [31:0] note_limit(input logic [HP_IDX_W-1:0] idx,
                                             input logic [31:0]          shamt);
    logic [31:0] hp;
    hp = HALF_P[idx] >> shamt;
    return (hp == 32'd0) ? 32'd1 : hp;
  endfunction

endpackage

// File: rtl/tone_synth_if.sv
// tone_synth_if: key/strobe inputs and DAC-side outputs of tone_synth.
//   sample_en   - DAC sample strobe (one cycle)
//   sw          - note keys, bit i selects note i
//   oct         - octave up-shift
//   vol         - amplitude, 0 = silent
//   speaker_out - sample to DAC
//   note_active - a note was sounding at the last sample
//   note_idx    - registered index of the selected note
//   master: key decoder / DAC driver side; slave: the synthesiser.
interface tone_synth_if #(
  parameter int NUM_NOTES = 7,
  parameter int OUT_W     = 12,
  parameter int VOL_W     = 4,
  parameter int OCT_W     = 2
);
  localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

  logic                 sample_en;
  logic [NUM_NOTES-1:0] sw;
  logic [OCT_W-1:0]     oct;
  logic [VOL_W-1:0]     vol;
  logic [OUT_W-1:0]     speaker_out;
  logic                 note_active;
  logic [IDX_W-1:0]     note_idx;

  modport master (
    output sample_en, sw, oct, vol,
    input  speaker_out, note_active, note_idx
  );

  modport slave (
    input  sample_en, sw, oct, vol,
    output speaker_out, note_active, note_idx
  );
endinterface

// File: rtl/tone_synth_divider.sv
// tone_divider: reloadable half-period divider.
//   clk_i, rst_i - clock, synchronous active-high reset
//   restart_i    - zero cnt and phase (wins over counting)
//   enable_i     - count when high; held at zero when low
//   limit_i      - cnt wraps after reaching this value (half-period limit+1)
//   phase_o      - square-wave phase, toggles on each wrap
module tone_divider #(
  parameter int CNT_W = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             restart_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             phase_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    phase_d = phase_q;
    if (restart_i || !enable_i) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == limit_i) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/tone_synth.sv
// tone_synth: square-wave note synthesiser feeding the speaker DAC.
//   CLK - system clock
//   RST - synchronous active-high reset
//   bus - tone_synth_if slave: sample_en, sw, oct, vol in;
//         speaker_out, note_active, note_idx out
// Lowest pressed key wins. Any change of the selected note or octave
// restarts the waveform from phase 0; outputs move only on sample_en.
module tone_synth
  import tone_pkg::*;
#(
  parameter int NUM_NOTES = 7,
  parameter int CNT_W     = 18,
  parameter int OUT_W     = 12,
  parameter int VOL_W     = 4,
  parameter int OCT_W     = 2
) (
  input  logic       CLK,
  input  logic       RST,
  tone_synth_if.slave bus
);

  localparam int IDX_W = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;

  // Key decode: scan high to low so the lowest set bit is the last write.
  logic             sel_valid;
  logic [IDX_W-1:0] sel_idx;

  assign sel_valid = |bus.sw;

  always_comb begin
    sel_idx = '0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (bus.sw[i]) sel_idx = IDX_W'(i);
    end
  end

  // Selection registers reload every cycle; a mismatch against the live
  // decode is exactly the restart condition.
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic [OCT_W-1:0] oct_q;
  logic             restart;

  assign restart = (sel_valid != valid_q) || (sel_idx != idx_q) || (bus.oct != oct_q);

  logic [31:0]      lim32;
  logic [CNT_W-1:0] limit;
  logic             phase;

  assign lim32 = note_limit(HP_IDX_W'(idx_q), 32'(oct_q));
  assign limit = CNT_W'(lim32);

  tone_divider #(.CNT_W(CNT_W)) u_div (
    .clk_i    (CLK),
    .rst_i    (RST),
    .restart_i(restart),
    .enable_i (valid_q),
    .limit_i  (limit),
    .phase_o  (phase)
  );

  // Output stage: vol is only looked at on the strobe, so a volume change
  // never disturbs the divider.
  logic [OUT_W-1:0] level;
  logic [OUT_W-1:0] spk_q, spk_d;
  logic             act_q, act_d;

  assign level = {(OUT_W / VOL_W){bus.vol}};

  always_comb begin
    spk_d = spk_q;
    act_d = act_q;
    if (bus.sample_en) begin
      spk_d = (valid_q && phase) ? level : '0;
      act_d = valid_q;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      oct_q   <= '0;
      spk_q   <= '0;
      act_q   <= 1'b0;
    end else begin
      idx_q   <= sel_idx;
      valid_q <= sel_valid;
      oct_q   <= bus.oct;
      spk_q   <= spk_d;
      act_q   <= act_d;
    end
  end

  assign bus.speaker_out = spk_q;
  assign bus.note_active = act_q;
  assign bus.note_idx    = idx_q;

endmodule

// File: tb/tb_tone_synth.sv
// Directed bench for tone_synth. A wide octave input lets real table
// entries shift down to short half-periods so every scenario stays short.
// Edge counts below: after the change edge E, edges are numbered 1,2,...;
// the first nonzero sample lands on edge limit+2 with sample_en held high.
module tb_tone_synth;
  import tone_pkg::*;

  localparam int NUM_NOTES = 7;
  localparam int CNT_W     = 18;
  localparam int OUT_W     = 12;
  localparam int VOL_W     = 4;
  localparam int OCT_W     = 5;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 CLK = ~CLK;

  tone_synth_if #(.NUM_NOTES(NUM_NOTES), .OUT_W(OUT_W), .VOL_W(VOL_W), .OCT_W(OCT_W)) bus ();

  tone_synth #(.NUM_NOTES(NUM_NOTES), .CNT_W(CNT_W), .OUT_W(OUT_W),
               .VOL_W(VOL_W), .OCT_W(OCT_W)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Drives one change edge, then measures first-rise edge, high run and low
  // run of speaker_out. Any -1 means the bound expired.
  task automatic measure(output logic [11:0] at_e, output int rise,
                         output int hi, output int lo);
    int c;
    rise = -1; hi = -1; lo = -1;
    tick;
    at_e = bus.speaker_out;
    tick;
    c = 1;
    while (c < 5000 && bus.speaker_out == '0) begin tick; c++; end
    if (bus.speaker_out == '0) return;
    rise = c;
    c = 0;
    while (c < 5000 && bus.speaker_out != '0) begin tick; c++; end
    if (bus.speaker_out != '0) return;
    hi = c;
    c = 0;
    while (c < 5000 && bus.speaker_out == '0) begin tick; c++; end
    if (bus.speaker_out == '0) return;
    lo = c;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    bus.sample_en = 1'b1; bus.sw = '0; bus.oct = '0; bus.vol = 4'hF;
    tick; tick;
    n_chk++; if (bus.speaker_out !== 12'h000) $display("FAIL reset_spk got %h want 000", bus.speaker_out); else n_pass++;
    n_chk++; if (bus.note_active !== 1'b0) $display("FAIL reset_act got %b want 0", bus.note_active); else n_pass++;
    n_chk++; if (bus.note_idx !== 3'd0) $display("FAIL reset_idx got %0d want 0", bus.note_idx); else n_pass++;
    RST = 1'b0;
    tick;
  endtask

  // DOH, oct 12: 191112>>12 = 46
  task automatic test_note_doh;
    logic [11:0] ae; int r, h, l;
    bus.sw = 7'b0000001; bus.oct = 5'd12; bus.vol = 4'hF;
    measure(ae, r, h, l);
    n_chk++; if (r !== 48) $display("FAIL doh_rise got %0d want 48", r); else n_pass++;
    n_chk++; if (h !== 47) $display("FAIL doh_high got %0d want 47", h); else n_pass++;
    n_chk++; if (l !== 47) $display("FAIL doh_low got %0d want 47", l); else n_pass++;
    n_chk++; if (bus.speaker_out !== 12'hFFF) $display("FAIL doh_level got %h want FFF", bus.speaker_out); else n_pass++;
    n_chk++; if (bus.note_active !== 1'b1) $display("FAIL doh_act got %b want 1", bus.note_active); else n_pass++;
    n_chk++; if (bus.note_idx !== 3'(N_DOH)) $display("FAIL doh_idx got %0d want 0", bus.note_idx); else n_pass++;
  endtask

  // oct 18 shifts DOH to 0, clamped to limit 1
  task automatic test_limit_clamp;
    logic [11:0] ae; int r, h, l;
    bus.oct = 5'd18;
    measure(ae, r, h, l);
    n_chk++; if (ae !== 12'hFFF) $display("FAIL clamp_pre got %h want FFF", ae); else n_pass++;
    n_chk++; if (r !== 3) $display("FAIL clamp_rise got %0d want 3", r); else n_pass++;
    n_chk++; if (h !== 2) $display("FAIL clamp_high got %0d want 2", h); else n_pass++;
    n_chk++; if (l !== 2) $display("FAIL clamp_low got %0d want 2", l); else n_pass++;
  endtask

  // RE (170261>>12 = 41) wins over MI; then MI alone (151685>>12 = 37)
  task automatic test_multikey_restart;
    logic [11:0] ae; int r, h, l;
    bus.sw = 7'b0000110; bus.oct = 5'd12;
    measure(ae, r, h, l);
    n_chk++; if (bus.note_idx !== 3'(N_RE)) $display("FAIL mk_idx got %0d want 1", bus.note_idx); else n_pass++;
    n_chk++; if (r !== 43) $display("FAIL mk_rise got %0d want 43", r); else n_pass++;
    n_chk++; if (h !== 42) $display("FAIL mk_high got %0d want 42", h); else n_pass++;
    bus.sw = 7'b0000100;
    measure(ae, r, h, l);
    n_chk++; if (ae !== 12'hFFF) $display("FAIL rs_pre_phase got %h want FFF", ae); else n_pass++;
    n_chk++; if (r !== 39) $display("FAIL rs_rise got %0d want 39", r); else n_pass++;
    n_chk++; if (h !== 38) $display("FAIL rs_high got %0d want 38", h); else n_pass++;
    n_chk++; if (bus.note_idx !== 3'(N_MI)) $display("FAIL rs_idx got %0d want 2", bus.note_idx); else n_pass++;
  endtask

  // Starts right at a rise edge, with 37 more high edges to go.
  task automatic test_volume;
    bus.vol = 4'h8; tick;
    n_chk++; if (bus.speaker_out !== 12'h888) $display("FAIL vol8 got %h want 888", bus.speaker_out); else n_pass++;
    bus.vol = 4'h0; tick;
    n_chk++; if (bus.speaker_out !== 12'h000) $display("FAIL vol0 got %h want 000", bus.speaker_out); else n_pass++;
    n_chk++; if (bus.note_active !== 1'b1) $display("FAIL vol0_act got %b want 1", bus.note_active); else n_pass++;
    bus.vol = 4'hF; tick;
    n_chk++; if (bus.speaker_out !== 12'hFFF) $display("FAIL vol_norestart got %h want FFF", bus.speaker_out); else n_pass++;
  endtask

  task automatic test_hold;
    bus.sample_en = 1'b0;
    repeat (100) tick;
    n_chk++; if (bus.speaker_out !== 12'hFFF) $display("FAIL hold_spk got %h want FFF", bus.speaker_out); else n_pass++;
    bus.sw = '0; tick; tick;
    n_chk++; if (bus.note_active !== 1'b1) $display("FAIL hold_act got %b want 1", bus.note_active); else n_pass++;
    bus.sample_en = 1'b1;
  endtask

  task automatic test_strobe;
    logic [11:0] prev, v;
    logic        se;
    int          viol, chg;
    viol = 0; chg = 0;
    bus.sw = 7'b0000001; bus.oct = 5'd12;
    prev = bus.speaker_out;
    for (int c = 0; c < 300; c++) begin
      se = (c % 5 == 0);
      bus.sample_en = se;
      tick;
      v = bus.speaker_out;
      if (v != 12'h000 && v != 12'hFFF) viol++;
      if (v != prev && !se) viol++;
      if (v != prev) chg++;
      prev = v;
    end
    n_chk++; if (viol !== 0) $display("FAIL strobe_viol got %0d want 0", viol); else n_pass++;
    n_chk++; if (chg < 4) $display("FAIL strobe_toggles got %0d want >=4", chg); else n_pass++;
    bus.sample_en = 1'b1;
  endtask

  task automatic test_release;
    bus.sw = '0;
    tick; tick;
    n_chk++; if (bus.speaker_out !== 12'h000) $display("FAIL rel_spk got %h want 000", bus.speaker_out); else n_pass++;
    n_chk++; if (bus.note_active !== 1'b0) $display("FAIL rel_act got %b want 0", bus.note_active); else n_pass++;
    n_chk++; if (bus.note_idx !== 3'd0) $display("FAIL rel_idx got %0d want 0", bus.note_idx); else n_pass++;
  endtask

  task automatic test_reset_mid_note;
    logic [11:0] ae; int r, h, l;
    bus.sw = 7'b0000001; bus.oct = 5'd12;
    measure(ae, r, h, l);
    n_chk++; if (bus.speaker_out !== 12'hFFF) $display("FAIL rm_pre got %h want FFF", bus.speaker_out); else n_pass++;
    RST = 1'b1; bus.sample_en = 1'b1;
    tick;
    n_chk++; if (bus.speaker_out !== 12'h000) $display("FAIL rm_spk got %h want 000", bus.speaker_out); else n_pass++;
    n_chk++; if (bus.note_active !== 1'b0) $display("FAIL rm_act got %b want 0", bus.note_active); else n_pass++;
    RST = 1'b0;
    measure(ae, r, h, l);
    n_chk++; if (ae !== 12'h000) $display("FAIL rm_at_e got %h want 000", ae); else n_pass++;
    n_chk++; if (r !== 48) $display("FAIL rm_rise got %0d want 48", r); else n_pass++;
    n_chk++; if (h !== 47) $display("FAIL rm_high got %0d want 47", h); else n_pass++;
  endtask

  initial begin
    bus.sample_en = 1'b0; bus.sw = '0; bus.oct = '0; bus.vol = '0;
    test_reset;
    test_note_doh;
    test_limit_clamp;
    test_multikey_restart;
    test_volume;
    test_hold;
    test_strobe;
    test_release;
    test_reset_mid_note;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
